// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request and reservation bundle for the regfile write-port arbiter.
// Master drives requests and reservations; the arbiter (slave) returns grants.
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 2
) ();
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [5*NUM_REQ-1:0]  req_reg;
    logic [32*NUM_REQ-1:0] req_data;
    logic                  rsv_valid;
    logic [4:0]            rsv_reg;
    logic                  rsv_ready;

    modport master (
        output req_valid,
        output req_reg,
        output req_data,
        output rsv_valid,
        output rsv_reg,
        input  req_ready,
        input  rsv_ready
    );

    modport slave (
        input  req_valid,
        input  req_reg,
        input  req_data,
        input  rsv_valid,
        input  rsv_reg,
        output req_ready,
        output rsv_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the regfile write port plus a pending-write
// scoreboard that flags read-after-write hazards for issue logic.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                clock,
    input  logic                ctrl_reset,
    regfile_wb_arbiter_if.slave wb,
    input  logic [4:0]          query_regA,
    input  logic [4:0]          query_regB,
    output logic                hazardA,
    output logic                hazardB,
    output logic                ctrl_writeEnable,
    output logic [4:0]          ctrl_writeReg,
    output logic [31:0]         data_writeReg,
    output logic [31:0]         busy_mask
);

    localparam logic [1:0] LAST_RST = 2'(NUM_REQ - 1);

    logic [1:0]         r_last;
    logic               r_we;
    logic [4:0]         r_wreg;
    logic [31:0]        r_wdata;
    logic [31:0]        r_busy;

    logic [NUM_REQ-1:0] w_grant;
    logic [1:0]         w_sel;
    logic [2:0]         w_best;
    logic [2:0]         w_dist;
    logic               w_accept;
    logic [4:0]         w_acc_reg;
    logic [31:0]        w_acc_data;
    logic               w_rsv_ready;
    logic               w_rsv_take;
    logic [31:0]        w_busy_nxt;

    // Pick the valid requester closest after r_last in rotation order.
    always_comb begin
        w_grant    = '0;
        w_sel      = r_last;
        w_best     = 3'd7;
        w_dist     = 3'd0;
        w_acc_reg  = 5'd0;
        w_acc_data = 32'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = 3'((i + 2*NUM_REQ - 1 - int'(r_last)) % NUM_REQ);
            if (wb.req_valid[i] && (w_dist < w_best)) begin
                w_best     = w_dist;
                w_grant    = '0;
                w_grant[i] = 1'b1;
                w_sel      = 2'(i);
                w_acc_reg  = wb.req_reg[5*i +: 5];
                w_acc_data = wb.req_data[32*i +: 32];
            end
        end
    end

    assign w_accept     = |w_grant;
    assign wb.req_ready = w_grant;

    assign w_rsv_ready  = ~r_busy[wb.rsv_reg];
    assign wb.rsv_ready = w_rsv_ready;
    assign w_rsv_take   = wb.rsv_valid & w_rsv_ready & (wb.rsv_reg != 5'd0);

    // Clear first so a same-cycle reservation of that register wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_accept)
            w_busy_nxt[w_acc_reg] = 1'b0;
        if (w_rsv_take)
            w_busy_nxt[wb.rsv_reg] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_last  <= LAST_RST;
            r_we    <= 1'b0;
            r_wreg  <= 5'd0;
            r_wdata <= 32'd0;
            r_busy  <= 32'd0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_accept)
                r_last <= w_sel;
            if (w_accept && (w_acc_reg != 5'd0)) begin
                r_we    <= 1'b1;
                r_wreg  <= w_acc_reg;
                r_wdata <= w_acc_data;
            end else begin
                r_we    <= 1'b0;
            end
        end
    end

    assign hazardA          = r_busy[query_regA];
    assign hazardB          = r_busy[query_regB];
    assign ctrl_writeEnable = r_we;
    assign ctrl_writeReg    = r_wreg;
    assign data_writeReg    = r_wdata;
    assign busy_mask        = r_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios plus a randomized run against a queue-free
// behavioural model of the arbiter and scoreboard.
module tb_regfile_wb_arbiter;

    localparam int N = 2;

    logic        clock;
    logic        ctrl_reset;
    logic [4:0]  query_regA;
    logic [4:0]  query_regB;
    logic        hazardA;
    logic        hazardB;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [31:0] busy_mask;

    int tests;
    int fails;

    regfile_wb_arbiter_if #(.NUM_REQ(N)) wb ();

    regfile_wb_arbiter #(.NUM_REQ(N)) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .wb               (wb.slave),
        .query_regA       (query_regA),
        .query_regB       (query_regB),
        .hazardA          (hazardA),
        .hazardB          (hazardB),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .busy_mask        (busy_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle_inputs();
        wb.req_valid = '0;
        wb.req_reg   = '0;
        wb.req_data  = '0;
        wb.rsv_valid = 1'b0;
        wb.rsv_reg   = 5'd0;
        query_regA   = 5'd0;
        query_regB   = 5'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        ctrl_reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        ctrl_reset = 1'b1;
    endtask

    task automatic test_reset();
        ctrl_reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            wb.req_valid = 2'($urandom);
            wb.req_reg   = 10'($urandom);
            wb.req_data  = {$urandom, $urandom};
            wb.rsv_valid = 1'($urandom);
            wb.rsv_reg   = 5'($urandom);
            @(posedge clock);
            #1;
            tests++;
            if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== 38'd0) begin
                fails++;
                $display("FAIL reset_outs got we=%b reg=%0d data=%h want 0",
                         ctrl_writeEnable, ctrl_writeReg, data_writeReg);
            end
            tests++;
            if (busy_mask !== 32'd0) begin
                fails++;
                $display("FAIL reset_busy got %h want 0", busy_mask);
            end
        end
        idle_inputs();
        ctrl_reset   = 1'b1;
        wb.req_valid = 2'b11;
        #1;
        tests++;
        if (wb.req_ready !== 2'b01) begin
            fails++;
            $display("FAIL reset_first_grant got %b want 01", wb.req_ready);
        end
        tests++;
        if ({wb.rsv_ready, hazardA, hazardB} !== 3'b100) begin
            fails++;
            $display("FAIL reset_rsv_haz got %b want 100",
                     {wb.rsv_ready, hazardA, hazardB});
        end
        idle_inputs();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [3];
        logic [4:0] exp_r [3];
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
        exp_r[0] = 5'd5;  exp_r[1] = 5'd6;  exp_r[2] = 5'd5;
        do_reset();
        wb.req_valid = 2'b11;
        wb.req_reg   = {5'd6, 5'd5};
        wb.req_data  = {32'hB, 32'hA};
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if (wb.req_ready !== exp_g[c]) begin
                fails++;
                $display("FAIL rr_grant%0d got %b want %b", c, wb.req_ready, exp_g[c]);
            end
            @(posedge clock);
            #1;
            tests++;
            if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== exp_r[c] ||
                data_writeReg !== ((exp_r[c] == 5'd5) ? 32'hA : 32'hB)) begin
                fails++;
                $display("FAIL rr_commit%0d got we=%b reg=%0d data=%h want reg %0d",
                         c, ctrl_writeEnable, ctrl_writeReg, data_writeReg, exp_r[c]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_r0_drop();
        do_reset();
        wb.req_valid = 2'b01;
        wb.req_reg   = {5'd6, 5'd0};
        wb.req_data  = {32'hB, 32'hFFFF_FFFF};
        #1;
        tests++;
        if (wb.req_ready !== 2'b01) begin
            fails++;
            $display("FAIL r0_grant got %b want 01", wb.req_ready);
        end
        @(posedge clock);
        #1;
        wb.req_valid = 2'b11;
        wb.req_reg   = {5'd6, 5'd5};
        tests++;
        if (ctrl_writeEnable !== 1'b0) begin
            fails++;
            $display("FAIL r0_we got %b want 0", ctrl_writeEnable);
        end
        #1;
        tests++;
        if (wb.req_ready !== 2'b10) begin
            fails++;
            $display("FAIL r0_last_adv got %b want 10", wb.req_ready);
        end
        idle_inputs();
    endtask

    task automatic test_reserve_commit();
        do_reset();
        wb.rsv_valid = 1'b1;
        wb.rsv_reg   = 5'd7;
        #1;
        tests++;
        if (wb.rsv_ready !== 1'b1) begin
            fails++;
            $display("FAIL rsv_first got %b want 1", wb.rsv_ready);
        end
        @(posedge clock);
        #1;
        query_regA = 5'd7;
        #1;
        tests++;
        if (busy_mask[7] !== 1'b1 || hazardA !== 1'b1) begin
            fails++;
            $display("FAIL rsv_busy got busy=%b haz=%b want 1 1", busy_mask[7], hazardA);
        end
        tests++;
        if (wb.rsv_ready !== 1'b0) begin
            fails++;
            $display("FAIL rsv_second got %b want 0", wb.rsv_ready);
        end
        wb.rsv_valid = 1'b0;
        wb.req_valid = 2'b10;
        wb.req_reg   = {5'd7, 5'd0};
        wb.req_data  = {32'h1234, 32'h0};
        @(posedge clock);
        #1;
        wb.req_valid = 2'b00;
        tests++;
        if (ctrl_writeEnable !== 1'b1 || data_writeReg !== 32'h1234 || hazardA !== 1'b0) begin
            fails++;
            $display("FAIL rsv_commit got we=%b data=%h haz=%b want 1 1234 0",
                     ctrl_writeEnable, data_writeReg, hazardA);
        end
        idle_inputs();
    endtask

    task automatic test_set_clear();
        do_reset();
        wb.rsv_valid = 1'b1;
        wb.rsv_reg   = 5'd9;
        wb.req_valid = 2'b01;
        wb.req_reg   = {5'd0, 5'd9};
        wb.req_data  = {32'h0, 32'h99};
        @(posedge clock);
        #1;
        idle_inputs();
        tests++;
        if (busy_mask[9] !== 1'b1 || ctrl_writeReg !== 5'd9) begin
            fails++;
            $display("FAIL set_clear got busy9=%b reg=%0d want 1 9", busy_mask[9], ctrl_writeReg);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        wb.req_valid = 2'b01;
        wb.req_reg   = {5'd0, 5'd3};
        wb.req_data  = {32'h0, 32'h55};
        wb.rsv_valid = 1'b1;
        wb.rsv_reg   = 5'd4;
        @(posedge clock);
        #1;
        idle_inputs();
        tests++;
        if (ctrl_writeEnable !== 1'b1 || busy_mask[4] !== 1'b1) begin
            fails++;
            $display("FAIL async_pre got we=%b busy4=%b want 1 1", ctrl_writeEnable, busy_mask[4]);
        end
        #1;
        ctrl_reset = 1'b0;
        #1;
        tests++;
        if (ctrl_writeEnable !== 1'b0 || busy_mask !== 32'd0 ||
            ctrl_writeReg !== 5'd0 || data_writeReg !== 32'd0) begin
            fails++;
            $display("FAIL async_clr got we=%b busy=%h reg=%0d data=%h want all 0",
                     ctrl_writeEnable, busy_mask, ctrl_writeReg, data_writeReg);
        end
        @(posedge clock);
        #1;
        ctrl_reset = 1'b1;
    endtask

    task automatic test_random();
        bit          pend [N];
        logic [4:0]  preg [N];
        logic [31:0] pdat [N];
        int          m_last;
        logic [31:0] m_busy;
        logic        m_we;
        logic [4:0]  m_reg;
        logic [31:0] m_data;
        int          win;
        logic [N-1:0] exp_rdy;
        logic        exp_rsv;
        do_reset();
        m_last = N - 1;
        m_busy = '0;
        m_we   = 1'b0;
        m_reg  = '0;
        m_data = '0;
        for (int i = 0; i < N; i++) pend[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1;
                    preg[i] = 5'($urandom_range(0, 15));
                    pdat[i] = $urandom;
                end
                wb.req_valid[i]         = pend[i];
                wb.req_reg[5*i +: 5]    = preg[i];
                wb.req_data[32*i +: 32] = pdat[i];
            end
            wb.rsv_valid = 1'($urandom);
            wb.rsv_reg   = 5'($urandom_range(0, 15));
            query_regA   = 5'($urandom_range(0, 15));
            query_regB   = 5'($urandom_range(0, 15));
            #1;
            win = -1;
            for (int k = 1; k <= N; k++) begin
                if (win < 0 && pend[(m_last + k) % N]) win = (m_last + k) % N;
            end
            exp_rdy = '0;
            if (win >= 0) exp_rdy[win] = 1'b1;
            exp_rsv = (wb.rsv_reg == 5'd0) ? 1'b1 : !m_busy[wb.rsv_reg];
            tests++;
            if (wb.req_ready !== exp_rdy) begin
                fails++;
                $display("FAIL rnd_grant c%0d got %b want %b", cyc, wb.req_ready, exp_rdy);
            end
            tests++;
            if (wb.rsv_ready !== exp_rsv || hazardA !== m_busy[query_regA] ||
                hazardB !== m_busy[query_regB]) begin
                fails++;
                $display("FAIL rnd_sb_comb c%0d got %b%b%b want %b%b%b", cyc,
                         wb.rsv_ready, hazardA, hazardB,
                         exp_rsv, m_busy[query_regA], m_busy[query_regB]);
            end
            m_we = 1'b0;
            if (win >= 0) begin
                m_last    = win;
                pend[win] = 0;
                m_busy[preg[win]] = 1'b0;
                if (preg[win] != 5'd0) begin
                    m_we   = 1'b1;
                    m_reg  = preg[win];
                    m_data = pdat[win];
                end
            end
            if (wb.rsv_valid && exp_rsv && wb.rsv_reg != 5'd0)
                m_busy[wb.rsv_reg] = 1'b1;
            m_busy[0] = 1'b0;
            @(posedge clock);
            #1;
            tests++;
            if (ctrl_writeEnable !== m_we || ctrl_writeReg !== m_reg || data_writeReg !== m_data) begin
                fails++;
                $display("FAIL rnd_commit c%0d got %b/%0d/%h want %b/%0d/%h", cyc,
                         ctrl_writeEnable, ctrl_writeReg, data_writeReg, m_we, m_reg, m_data);
            end
            tests++;
            if (busy_mask !== m_busy) begin
                fails++;
                $display("FAIL rnd_busy c%0d got %h want %h", cyc, busy_mask, m_busy);
            end
        end
        idle_inputs();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        idle_inputs();
        ctrl_reset = 1'b0;
        #2;
        test_reset();
        test_round_robin();
        test_r0_drop();
        test_reserve_commit();
        test_set_clear();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
